// File: rtl/mem_to_com.sv
// -----------------------------------------------------------------------------
// mem_to_com
// Frame-buffer readout engine. On i_start it walks every pixel of the 12-bit
// RGB444 frame BRAM and hands bytes one at a time to a UART transmitter:
//   HEADER0, HEADER1, {4'h0,R},{G,B} per pixel, XOR checksum of pixel bytes.
//
// Ports
//   clk          system clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle start request, honoured only when idle
//   i_abort      level, forces the engine back to idle on the next edge
//   o_addr_rd    BRAM read address
//   i_data_rd    BRAM read data, valid one clock after o_addr_rd
//   o_tx_dv      one-cycle byte-valid strobe to the UART transmitter
//   o_tx_byte    byte to transmit, held from o_tx_dv until i_tx_done
//   i_tx_active  UART transmitter busy
//   i_tx_done    one-cycle UART byte-complete pulse
//   o_busy       high from accepted start until return to idle
//   o_done       one-cycle pulse after the checksum byte has completed
// -----------------------------------------------------------------------------
module mem_to_com #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 76_800,
  parameter logic [7:0]  HEADER0    = 8'hA5,
  parameter logic [7:0]  HEADER1    = 8'h5A
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  input  logic [DATA_WIDTH-1:0] i_data_rd,
  output logic                  o_tx_dv,
  output logic [7:0]            o_tx_byte,
  input  logic                  i_tx_active,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_RD,
    S_RD_WAIT,
    S_PIX_HI,
    S_PIX_LO,
    S_CSUM,
    S_FIN
  } state_t;

  state_t                r_state;
  logic                  r_sent;   // byte of the current state already strobed
  logic [7:0]            r_csum;
  logic [DATA_WIDTH-1:0] r_pix;

  logic [7:0] w_byte;
  logic       w_is_byte;
  logic       w_is_pix;
  logic       w_strobe;
  logic       w_adv;

  // Byte associated with the current state, and whether it feeds the checksum
  always_comb begin
    w_byte    = 8'h00;
    w_is_byte = 1'b0;
    w_is_pix  = 1'b0;
    case (r_state)
      S_HDR0: begin
        w_byte    = HEADER0;
        w_is_byte = 1'b1;
      end
      S_HDR1: begin
        w_byte    = HEADER1;
        w_is_byte = 1'b1;
      end
      S_PIX_HI: begin
        w_byte    = {4'h0, r_pix[11:8]};
        w_is_byte = 1'b1;
        w_is_pix  = 1'b1;
      end
      S_PIX_LO: begin
        w_byte    = r_pix[7:0];
        w_is_byte = 1'b1;
        w_is_pix  = 1'b1;
      end
      S_CSUM: begin
        w_byte    = r_csum;
        w_is_byte = 1'b1;
      end
      default: begin
        w_byte    = 8'h00;
        w_is_byte = 1'b0;
        w_is_pix  = 1'b0;
      end
    endcase
  end

  // Strobe once per byte state; advance only on the completion of our own byte
  assign w_strobe = w_is_byte && !r_sent && !i_tx_active;
  assign w_adv    = w_is_byte &&  r_sent &&  i_tx_done;

  // Sequencer with registered outputs
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_sent    <= 1'b0;
      r_csum    <= 8'h00;
      r_pix     <= '0;
      o_addr_rd <= '0;
      o_tx_dv   <= 1'b0;
      o_tx_byte <= 8'h00;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else if (i_abort) begin
      // A byte already handed to the UART finishes there on its own
      r_state <= S_IDLE;
      r_sent  <= 1'b0;
      o_tx_dv <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_tx_dv <= 1'b0;
      o_done  <= 1'b0;

      if (w_strobe) begin
        o_tx_dv   <= 1'b1;
        o_tx_byte <= w_byte;
        r_sent    <= 1'b1;
        if (w_is_pix) begin
          r_csum <= r_csum ^ w_byte;
        end
      end

      if (w_adv) begin
        r_sent <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_HDR0;
            r_sent    <= 1'b0;
            r_csum    <= 8'h00;
            o_addr_rd <= '0;
            o_busy    <= 1'b1;
          end else begin
            o_busy <= 1'b0;
          end
        end
        S_HDR0: begin
          if (w_adv) begin
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_adv) begin
            r_state <= S_RD;
          end
        end
        S_RD: begin
          // o_addr_rd already holds this pixel's address
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_pix   <= i_data_rd;
          r_state <= S_PIX_HI;
        end
        S_PIX_HI: begin
          if (w_adv) begin
            r_state <= S_PIX_LO;
          end
        end
        S_PIX_LO: begin
          if (w_adv) begin
            if (o_addr_rd == LAST_ADDR) begin
              r_state <= S_CSUM;
            end else begin
              o_addr_rd <= o_addr_rd + ADDR_WIDTH'(1);
              r_state   <= S_RD;
            end
          end
        end
        S_CSUM: begin
          // o_done is high for exactly the FIN cycle
          if (w_adv) begin
            r_state <= S_FIN;
            o_done  <= 1'b1;
          end
        end
        S_FIN: begin
          o_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_to_com.sv
// -----------------------------------------------------------------------------
// tb_mem_to_com
// Bench for mem_to_com with DEPTH=4: BRAM model (1-clk latency), UART model
// (10-clk bytes) capturing every strobed byte, and a byte-stream reference
// built from the frame contents.
// -----------------------------------------------------------------------------
module tb_mem_to_com;

  localparam int unsigned AW        = 3;
  localparam int unsigned DW        = 12;
  localparam int unsigned DEPTH     = 4;
  localparam int          BYTE_CLKS = 10;
  localparam int          LIMIT     = 2000;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [DEPTH-1:0][11:0] pix;
    logic [7:0]             csum;
    logic                   stall;
    logic                   mid;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          stall;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] data_rd;
  logic          tx_dv;
  logic [7:0]    tx_byte;
  logic          tx_active;
  logic          tx_done;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  mem_to_com #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .HEADER0   (8'hA5),
    .HEADER1   (8'h5A)
  ) u_dut (
    .clk        (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_abort    (abort),
    .o_addr_rd  (addr_rd),
    .i_data_rd  (data_rd),
    .o_tx_dv    (tx_dv),
    .o_tx_byte  (tx_byte),
    .i_tx_active(tx_active),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_done     (done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // BRAM model: one clock read latency
  logic [11:0] mem [DEPTH];
  always @(posedge clk) begin
    if (int'(addr_rd) < int'(DEPTH)) data_rd <= mem[addr_rd];
    else                             data_rd <= 12'hEEE;
  end

  // UART model: accepts a strobe, is active BYTE_CLKS clocks, pulses done
  int         u_cnt = 0;
  logic       u_act;
  logic [7:0] u_byte;
  bq_t        cap;
  int         dv_cnt   = 0;
  int         done_cnt = 0;
  int         txd_cnt  = 0;

  assign tx_active = u_act | stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      u_cnt = 0;
      u_act   <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      if (tx_done) txd_cnt++;
      if (done)    done_cnt++;
      check("addr_bound", 32'(int'(addr_rd) < int'(DEPTH)), 32'd1);
      tx_done <= 1'b0;
      if (tx_dv) begin
        check("dv_while_uart_busy", 32'(u_cnt), 32'd0);
        dv_cnt++;
        cap.push_back(tx_byte);
        u_byte = tx_byte;
        u_cnt  = BYTE_CLKS;
        u_act <= 1'b1;
      end else if (u_cnt > 0) begin
        u_cnt--;
        if (u_cnt == 0) begin
          check("byte_stable", 32'(tx_byte), 32'(u_byte));
          u_act   <= 1'b0;
          tx_done <= 1'b1;
        end
      end
    end
  end

  // Reference stream from the frame contents
  function automatic void build_exp(output bq_t q);
    int x;
    x = 0;
    q = {};
    q.push_back(8'hA5);
    q.push_back(8'h5A);
    for (int i = 0; i < int'(DEPTH); i++) begin
      int p;
      int hi;
      int lo;
      p  = int'(mem[i]);
      hi = p / 256;
      lo = p % 256;
      q.push_back(8'(hi));
      q.push_back(8'(lo));
      x = x ^ hi ^ lo;
    end
    q.push_back(8'(x));
  endfunction

  function automatic logic [7:0] csum_of(input logic [DEPTH-1:0][11:0] pix);
    int x;
    x = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      int p;
      p = int'(pix[i]);
      x = x ^ (p / 256) ^ (p % 256);
    end
    return 8'(x);
  endfunction

  task automatic load(input logic [DEPTH-1:0][11:0] pix);
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = pix[i];
  endtask

  // Runs one frame from IDLE (called #1 after a clock edge)
  task automatic run_frame(input int id, input logic stall50, input logic mid,
                           input logic [7:0] exp_csum);
    bq_t exp;
    int  dv0;
    int  dn0;
    int  cyc;
    int  n;
    build_exp(exp);
    cap.delete();
    dv0   = dv_cnt;
    dn0   = done_cnt;
    stall = stall50;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("f%0d_busy_rise", id), 32'(busy), 32'd1);
    check($sformatf("f%0d_no_dv_at_busy_rise", id), 32'(tx_dv), 32'd0);
    if (stall50) begin
      repeat (50) @(posedge clk);
      #1;
      check($sformatf("f%0d_stall_no_dv", id), 32'(dv_cnt - dv0), 32'd0);
      stall = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
      start = mid && (cyc == 60);
    end
    start = 1'b0;
    check($sformatf("f%0d_done_seen", id), 32'(done), 32'd1);
    check($sformatf("f%0d_busy_at_done", id), 32'(busy), 32'd1);
    @(posedge clk); #1;
    check($sformatf("f%0d_done_one_cycle", id), 32'(done), 32'd0);
    check($sformatf("f%0d_busy_fall", id), 32'(busy), 32'd0);
    check($sformatf("f%0d_byte_count", id), 32'(cap.size()), 32'(2 * DEPTH + 3));
    check($sformatf("f%0d_dv_count", id), 32'(dv_cnt - dv0), 32'(2 * DEPTH + 3));
    check($sformatf("f%0d_done_count", id), 32'(done_cnt - dn0), 32'd1);
    n = (cap.size() < exp.size()) ? cap.size() : exp.size();
    for (int i = 0; i < n; i++)
      check($sformatf("f%0d_byte%0d", id, i), 32'(cap[i]), 32'(exp[i]));
    if (cap.size() > 0)
      check($sformatf("f%0d_csum", id), 32'(cap[cap.size() - 1]), 32'(exp_csum));
  endtask

  vec_t tv[7];
  bq_t  first;
  int   cyc;
  int   t0;
  int   dvs;
  int   dns;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 12'h000;

    tv[0].pix = {12'hABC, 12'h789, 12'h456, 12'h123}; tv[0].csum = 8'h48; tv[0].stall = 1'b0; tv[0].mid = 1'b0;
    tv[1].pix = {12'hABC, 12'h789, 12'h456, 12'h123}; tv[1].csum = 8'h48; tv[1].stall = 1'b1; tv[1].mid = 1'b0;
    tv[2].pix = {12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF}; tv[2].csum = 8'h00; tv[2].stall = 1'b0; tv[2].mid = 1'b1;
    tv[3].pix = {12'h100, 12'h001, 12'h0F0, 12'hF0F}; tv[3].csum = 8'hF0; tv[3].stall = 1'b0; tv[3].mid = 1'b0;
    for (int k = 4; k < 7; k++) begin
      for (int i = 0; i < int'(DEPTH); i++) tv[k].pix[i] = 12'($urandom_range(0, 4095));
      tv[k].csum  = csum_of(tv[k].pix);
      tv[k].stall = 1'b0;
      tv[k].mid   = 1'($urandom_range(0, 1));
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_addr", 32'(addr_rd), 32'd0);
    check("rst_dv", 32'(tx_dv), 32'd0);
    check("rst_byte", 32'(tx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven frames
    for (int k = 0; k < 7; k++) begin
      load(tv[k].pix);
      run_frame(k, tv[k].stall, tv[k].mid, tv[k].csum);
      repeat (3) @(posedge clk);
      #1;
    end

    // Abort after the 5th byte completes, then restart cleanly
    load(tv[0].pix);
    cap.delete();
    t0 = txd_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((txd_cnt - t0) < 5 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_reach_5_bytes", 32'(txd_cnt - t0), 32'd5);
    dns = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_dv", 32'(tx_dv), 32'd0);
    dvs = dv_cnt;
    repeat (40) @(posedge clk);
    #1;
    check("abort_no_more_dv", 32'(dv_cnt - dvs), 32'd0);
    check("abort_no_done", 32'(done_cnt - dns), 32'd0);
    check("abort_bytes_sent", 32'(cap.size()), 32'd5);
    run_frame(20, 1'b0, 1'b0, 8'h48);

    // Start and abort together in IDLE: abort wins
    dvs = dv_cnt;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("start_abort_no_dv", 32'(dv_cnt - dvs), 32'd0);

    // Asynchronous reset in the middle of pixel 1
    load(tv[0].pix);
    cap.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cap.size() < 5 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rstmid_reach_5", 32'(cap.size()), 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_addr", 32'(addr_rd), 32'd0);
    check("rstmid_dv", 32'(tx_dv), 32'd0);
    check("rstmid_byte", 32'(tx_byte), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dvs = dv_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("rstmid_idle_busy", 32'(busy), 32'd0);
    check("rstmid_idle_no_dv", 32'(dv_cnt - dvs), 32'd0);

    // Back-to-back frames, start on the cycle after o_done
    load({12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF});
    run_frame(30, 1'b0, 1'b0, 8'h00);
    first = cap;
    run_frame(31, 1'b0, 1'b0, 8'h00);
    check("b2b_len", 32'(cap.size()), 32'(first.size()));
    for (int i = 0; i < first.size() && i < cap.size(); i++)
      check($sformatf("b2b_byte%0d", i), 32'(cap[i]), 32'(first[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
